// File: rtl/byte_striping_pkg.sv
// Shared definitions for the two-lane byte striper (transmit side).
// Holds the default word width, the pairing FSM encoding, the lane hold
// length shared with the receive-side unstriper, and a counter-width helper.
package byte_striping_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    // Each lane load is presented for one clk_f period = two clk_2f cycles.
    localparam int LANE_HOLD = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HALF = 1'b1
    } state_e;

    // Idle counter width; never below 1 bit so FLUSH_CYCLES=0 still elaborates.
    function automatic int cnt_width(input int flush_cycles);
        return (flush_cycles < 1) ? 1 : $clog2(flush_cycles + 1);
    endfunction

endpackage

// File: rtl/byte_striping_if.sv
// Word-source and lane-side signals of the byte striper.
//   valid_in / data_in          : word stream from the MAC side
//   lane_0 / valid_0            : even word of the current pair
//   lane_1 / valid_1            : odd word of the current pair
//   lane_stb                    : one-cycle pulse on each new lane load
// slave  = the striper, master = whatever feeds words and consumes lanes.
interface byte_striping_if
    import byte_striping_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] lane_0;
    logic                  valid_0;
    logic [DATA_WIDTH-1:0] lane_1;
    logic                  valid_1;
    logic                  lane_stb;

    modport master (
        output valid_in, data_in,
        input  lane_0, valid_0, lane_1, valid_1, lane_stb
    );

    modport slave (
        input  valid_in, data_in,
        output lane_0, valid_0, lane_1, valid_1, lane_stb
    );
endinterface

// File: rtl/byte_striping.sv
// Two-lane byte striper: even words to lane 0, odd words to lane 1, each pair
// held on both lanes for two clk_2f cycles. A lone even word is flushed onto
// lane 0 after FLUSH_CYCLES idle cycles (0 disables flushing).
// Ports:
//   clk_2f   : single clock, all logic on posedge
//   reset_L  : asynchronous active-low reset
//   bus      : byte_striping_if slave (word input, lanes, valids, lane_stb)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no pending word; next accepted word is even
// ST_HALF | even word parked in hold_q, waiting for its odd partner
module byte_striping
    import byte_striping_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic             clk_2f,
    input  logic             reset_L,
    byte_striping_if.slave   bus
);

    localparam int            CW        = cnt_width(FLUSH_CYCLES);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] FLUSH_AT  = CW'(FLUSH_CYCLES);
    localparam logic          FLUSH_EN  = (FLUSH_CYCLES != 0);
    localparam logic          HOLD_INIT = 1'(LANE_HOLD - 1);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] lane_0_q;
    logic [DATA_WIDTH-1:0] lane_1_q;
    logic                  valid_0_q;
    logic                  valid_1_q;
    logic                  stb_q;
    logic                  hold_cnt_q;
    logic [CW-1:0]         idle_cnt_q;
    logic [CW-1:0]         idle_cnt_d;
    logic                  load_pair;
    logic                  load_flush;

    always_comb begin
        idle_cnt_d = (idle_cnt_q == CNT_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
        load_pair  = (state_q == ST_HALF) && bus.valid_in;
        // Flush fires on the idle cycle that brings the counter up to FLUSH_CYCLES.
        load_flush = (state_q == ST_HALF) && !bus.valid_in && FLUSH_EN
                     && (idle_cnt_d == FLUSH_AT);
    end

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            lane_0_q   <= '0;
            lane_1_q   <= '0;
            valid_0_q  <= 1'b0;
            valid_1_q  <= 1'b0;
            stb_q      <= 1'b0;
            hold_cnt_q <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            stb_q <= load_pair | load_flush;

            case (state_q)
                ST_IDLE: begin
                    if (bus.valid_in) begin
                        hold_q     <= bus.data_in;
                        idle_cnt_q <= '0;
                        state_q    <= ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (load_pair || load_flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        idle_cnt_q <= idle_cnt_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // A new load always wins over the tail of the previous hold window.
            if (load_pair) begin
                lane_0_q   <= hold_q;
                lane_1_q   <= bus.data_in;
                valid_0_q  <= 1'b1;
                valid_1_q  <= 1'b1;
                hold_cnt_q <= HOLD_INIT;
            end else if (load_flush) begin
                lane_0_q   <= hold_q;
                lane_1_q   <= '0;
                valid_0_q  <= 1'b1;
                valid_1_q  <= 1'b0;
                hold_cnt_q <= HOLD_INIT;
            end else if (hold_cnt_q) begin
                hold_cnt_q <= 1'b0;
            end else begin
                lane_0_q  <= '0;
                lane_1_q  <= '0;
                valid_0_q <= 1'b0;
                valid_1_q <= 1'b0;
            end
        end
    end

    assign bus.lane_0   = lane_0_q;
    assign bus.valid_0  = valid_0_q;
    assign bus.lane_1   = lane_1_q;
    assign bus.valid_1  = valid_1_q;
    assign bus.lane_stb = stb_q;

endmodule

// File: tb/tb_byte_striping.sv
module tb_byte_striping;

    logic clk;
    logic rst_l;
    int   checks;
    int   failures;
    int   cyc;

    byte_striping_if #(.DATA_WIDTH(32)) bus ();

    byte_striping #(.DATA_WIDTH(32), .FLUSH_CYCLES(4)) dut (
        .clk_2f  (clk),
        .reset_L (rst_l),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        vin;
        logic [31:0] din;
        logic        stb;
        logic        v0;
        logic [31:0] l0;
        logic        v1;
        logic [31:0] l1;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] l0;
        logic        v0;
        logic [31:0] l1;
        logic        v1;
        int          at;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    logic [31:0] in_words[$];
    logic [31:0] out_words[$];

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    function automatic void add(input logic vin, input logic [31:0] din, input logic stb,
                                input logic v0, input logic [31:0] l0,
                                input logic v1, input logic [31:0] l1, input string name);
        vec_t v;
        v.vin = vin; v.din = din; v.stb = stb; v.v0 = v0; v.l0 = l0;
        v.v1 = v1; v.l1 = l1; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic check_out(input string name, input logic stb, input logic v0,
                             input logic [31:0] l0, input logic v1, input logic [31:0] l1);
        checks++;
        if (bus.lane_stb !== stb || bus.valid_0 !== v0 || bus.lane_0 !== l0 ||
            bus.valid_1 !== v1 || bus.lane_1 !== l1) begin
            failures++;
            $display("FAIL %s @cyc %0d: got stb=%b v0=%b l0=%h v1=%b l1=%h, expected stb=%b v0=%b l0=%h v1=%b l1=%h",
                     name, cyc, bus.lane_stb, bus.valid_0, bus.lane_0, bus.valid_1, bus.lane_1,
                     stb, v0, l0, v1, l1);
        end
    endtask

    task automatic step(input logic vin, input logic [31:0] din);
        @(negedge clk);
        bus.valid_in = vin;
        bus.data_in  = din;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Spec-level pairing bookkeeping for the random run.
    logic        m_pend;
    logic [31:0] m_word;
    int          m_idle;

    task automatic rstep(input logic vin, input logic [31:0] din);
        exp_t e;
        logic exp_stb;
        if (vin) begin
            in_words.push_back(din);
            if (!m_pend) begin
                m_pend = 1'b1; m_word = din; m_idle = 0;
            end else begin
                e.l0 = m_word; e.v0 = 1'b1; e.l1 = din; e.v1 = 1'b1; e.at = cyc + 1;
                sb.push_back(e);
                m_pend = 1'b0;
            end
        end else if (m_pend) begin
            m_idle++;
            if (m_idle == 4) begin
                e.l0 = m_word; e.v0 = 1'b1; e.l1 = '0; e.v1 = 1'b0; e.at = cyc + 1;
                sb.push_back(e);
                m_pend = 1'b0;
            end
        end
        step(vin, din);
        exp_stb = (sb.size() > 0) && (sb[0].at == cyc);
        checks++;
        if (bus.lane_stb !== exp_stb) begin
            failures++;
            $display("FAIL rand_stb @cyc %0d: got lane_stb=%b, expected %b", cyc, bus.lane_stb, exp_stb);
        end
        if (exp_stb) begin
            e = sb.pop_front();
            check_out("rand_load", 1'b1, e.v0, e.l0, e.v1, e.l1);
            if (bus.valid_0 === 1'b1) out_words.push_back(bus.lane_0);
            if (bus.valid_1 === 1'b1) out_words.push_back(bus.lane_1);
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        m_pend = 1'b0; m_word = '0; m_idle = 0;
        rst_l = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;

        #12;
        check_out("reset_state", 1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        rst_l = 1'b1;

        // Long idle after reset: nothing may appear.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, JUNK);
            check_out("idle_after_reset", 1'b0, 1'b0, '0, 1'b0, '0);
        end

        // Back-to-back words.
        add(1, 32'hA000_0000, 0, 0, '0, 0, '0, "b2b_A0");
        add(1, 32'hA000_0001, 1, 1, 32'hA000_0000, 1, 32'hA000_0001, "b2b_A1_load");
        add(1, 32'hA000_0002, 0, 1, 32'hA000_0000, 1, 32'hA000_0001, "b2b_A2_hold");
        add(1, 32'hA000_0003, 1, 1, 32'hA000_0002, 1, 32'hA000_0003, "b2b_A3_load");
        add(0, JUNK,          0, 1, 32'hA000_0002, 1, 32'hA000_0003, "b2b_hold");
        add(0, JUNK,          0, 0, '0, 0, '0, "b2b_clear");
        // Gap shorter than the flush limit.
        add(1, 32'hB000_0000, 0, 0, '0, 0, '0, "gap_B0");
        add(0, JUNK,          0, 0, '0, 0, '0, "gap_idle1");
        add(0, JUNK,          0, 0, '0, 0, '0, "gap_idle2");
        add(1, 32'hB000_0001, 1, 1, 32'hB000_0000, 1, 32'hB000_0001, "gap_B1_load");
        add(0, JUNK,          0, 1, 32'hB000_0000, 1, 32'hB000_0001, "gap_hold");
        add(0, JUNK,          0, 0, '0, 0, '0, "gap_clear");
        // Lone even word flushed after 4 idle cycles, then a fresh pair.
        add(1, 32'hC000_0000, 0, 0, '0, 0, '0, "flush_C0");
        add(0, JUNK,          0, 0, '0, 0, '0, "flush_idle1");
        add(0, JUNK,          0, 0, '0, 0, '0, "flush_idle2");
        add(0, JUNK,          0, 0, '0, 0, '0, "flush_idle3");
        add(0, JUNK,          1, 1, 32'hC000_0000, 0, '0, "flush_load");
        add(0, JUNK,          0, 1, 32'hC000_0000, 0, '0, "flush_hold");
        add(0, JUNK,          0, 0, '0, 0, '0, "flush_clear");
        add(1, 32'hD000_0000, 0, 0, '0, 0, '0, "after_flush_D0");
        add(1, 32'hD000_0001, 1, 1, 32'hD000_0000, 1, 32'hD000_0001, "after_flush_D1");
        add(0, JUNK,          0, 1, 32'hD000_0000, 1, 32'hD000_0001, "after_flush_hold");
        add(0, JUNK,          0, 0, '0, 0, '0, "after_flush_clear");
        // Pair then a parked even word, used by the async reset sequence below.
        add(1, 32'h6000_0000, 0, 0, '0, 0, '0, "pre_rst_G0");
        add(1, 32'h6000_0001, 1, 1, 32'h6000_0000, 1, 32'h6000_0001, "pre_rst_G1");
        add(1, 32'hE000_0000, 0, 1, 32'h6000_0000, 1, 32'h6000_0001, "pre_rst_E0");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].vin, vecs[i].din);
            check_out(vecs[i].name, vecs[i].stb, vecs[i].v0, vecs[i].l0, vecs[i].v1, vecs[i].l1);
        end

        // Asynchronous reset in the middle of a cycle, while E0 is pending.
        #2;
        rst_l = 1'b0;
        #1;
        check_out("async_reset", 1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        bus.valid_in = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        step(1'b1, 32'hF000_0000);
        check_out("post_rst_F0", 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b1, 32'hF000_0001);
        check_out("post_rst_F1_load", 1'b1, 1'b1, 32'hF000_0000, 1'b1, 32'hF000_0001);
        step(1'b0, JUNK);
        check_out("post_rst_hold", 1'b0, 1'b1, 32'hF000_0000, 1'b1, 32'hF000_0001);
        step(1'b0, JUNK);
        check_out("post_rst_clear", 1'b0, 1'b0, '0, 1'b0, '0);

        // Random words with random gaps (some long enough to flush).
        for (int i = 0; i < 64; i++) begin
            int gap;
            gap = $urandom_range(0, 6);
            for (int g = 0; g < gap; g++) rstep(1'b0, $urandom);
            rstep(1'b1, $urandom);
        end
        for (int i = 0; i < 8; i++) rstep(1'b0, $urandom);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rand_drain: %0d expected loads never seen, required 0", sb.size());
        end
        checks++;
        if (out_words != in_words) begin
            failures++;
            $display("FAIL loopback_order: got %0d words out, required %0d words in same order",
                     out_words.size(), in_words.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
